// File: rtl/booth_ctrl_pkg.sv
// Shared types and widths for the Booth multiplier front-end arbiter.
package booth_ctrl_pkg;
  localparam int unsigned OPW = 8;
  localparam int unsigned PRW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_READ_HI,
    S_READ_LO,
    S_RESP
  } state_t;
endpackage

// File: rtl/booth_arbiter_if.sv
// Byte-wide operand/result bus between the arbiter and the Booth multiplier.
interface booth_arbiter_if;
  import booth_ctrl_pkg::*;

  logic           mul_bgn;
  logic [OPW-1:0] mul_ibus;
  logic [OPW-1:0] mul_obus;
  logic           mul_stop;

  modport master (output mul_bgn, output mul_ibus, input mul_obus, input mul_stop);
  modport slave  (input mul_bgn, input mul_ibus, output mul_obus, output mul_stop);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin tie-break: a lone request wins, a tie goes to the
// requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant from the current requests and the last-served index
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/booth_arbiter.sv
// Arbitrates two requesters onto a shared byte-serial Booth multiplier.
// Optional watchdog on the WAIT state: define BOOTH_ARB_TIMEOUT_EN.
module booth_arbiter
  import booth_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [1:0]      req_i,
  input  logic [OPW-1:0]  a0_i,
  input  logic [OPW-1:0]  b0_i,
  input  logic [OPW-1:0]  a1_i,
  input  logic [OPW-1:0]  b1_i,
  output logic [1:0]      done_o,
  output logic [PRW-1:0]  prod_o,
  output logic            err_o,
  output logic            busy_o,
  booth_arbiter_if.master mul
);

  state_t         state;
  logic           gnt_id;
  logic           last;
  logic [OPW-1:0] b_q;
  logic [OPW-1:0] hi_q;
  logic [OPW-1:0] lo_q;
  logic [1:0]     grant;
  logic [1:0]     done_q;
  logic [PRW-1:0] prod_q;
  logic           busy_q;
  logic           bgn_q;
  logic [OPW-1:0] ibus_q;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
`endif

  rr_arb2 u_arb (
    .req   (req_i),
    .last  (last),
    .grant (grant)
  );

  // Controller FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= S_IDLE;
      gnt_id <= 1'b0;
      last   <= 1'b1;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= '0;
      prod_q <= '0;
      busy_q <= 1'b0;
      bgn_q  <= 1'b0;
      ibus_q <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      cnt    <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|req_i) begin
            // ibus_q doubles as the latched multiplicand
            gnt_id <= grant[1];
            ibus_q <= grant[1] ? a1_i : a0_i;
            b_q    <= grant[1] ? b1_i : b0_i;
            bgn_q  <= 1'b1;
            busy_q <= 1'b1;
            state  <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          ibus_q <= b_q;
          state  <= S_LOAD_B;
        end
        S_LOAD_B: begin
          bgn_q  <= 1'b0;
          ibus_q <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
          cnt    <= '0;
`endif
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (mul.mul_stop) begin
            hi_q  <= mul.mul_obus;
            state <= S_READ_HI;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            prod_q <= '0;
            err_q  <= 1'b1;
            done_q <= gnt_id ? 2'b10 : 2'b01;
            state  <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_READ_HI: begin
          lo_q  <= mul.mul_obus;
          state <= S_READ_LO;
        end
        S_READ_LO: begin
          prod_q <= {hi_q, lo_q};
          last   <= gnt_id;
          done_q <= gnt_id ? 2'b10 : 2'b01;
          state  <= S_RESP;
        end
        S_RESP: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done_o       = done_q;
  assign prod_o       = prod_q;
  assign busy_o       = busy_q;
  assign mul.mul_bgn  = bgn_q;
  assign mul.mul_ibus = ibus_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_booth_arbiter.sv
// Scoreboard bench for booth_arbiter with a behavioural Booth multiplier model.
module tb_booth_arbiter;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  req_i = '0;
  logic [7:0]  a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
  logic [1:0]  done_o;
  logic [15:0] prod_o;
  logic        err_o;
  logic        busy_o;

  booth_arbiter_if mul ();

  booth_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .req_i  (req_i),
    .a0_i   (a0_i),
    .b0_i   (b0_i),
    .a1_i   (a1_i),
    .b1_i   (b1_i),
    .done_o (done_o),
    .prod_o (prod_o),
    .err_o  (err_o),
    .busy_o (busy_o),
    .mul    (mul)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] done; logic [15:0] prod; logic err; } exp_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic hang; } op_t;

  exp_t exp_q[$];
  op_t  op_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_srv = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p);
  endfunction

  // Behavioural multiplier: takes two operand bytes, answers hi then lo byte
  initial begin
    logic [7:0]  ma, mb;
    logic [15:0] pv;
    op_t         o;
    mul.mul_stop = 1'b0;
    mul.mul_obus = '0;
    forever begin
      @(negedge clk);
      if (rst_b && mul.mul_bgn) begin
        ma = mul.mul_ibus;
        @(negedge clk);
        check("bgn_second_cycle", 32'(mul.mul_bgn), 32'd1);
        mb = mul.mul_ibus;
        o.hang = 1'b0;
        if (op_q.size() == 0) begin
          check("operand_expected", 32'd0, 32'd1);
        end else begin
          o = op_q.pop_front();
          check("ibus_a", 32'(ma), 32'(o.a));
          check("ibus_b", 32'(mb), 32'(o.b));
        end
        pv = smul(ma, mb);
        if (!o.hang) begin
          @(negedge clk);
          repeat ($urandom_range(0, 4)) @(negedge clk);
          mul.mul_stop = 1'b1;
          mul.mul_obus = pv[15:8];
          @(negedge clk);
          mul.mul_stop = 1'b0;
          mul.mul_obus = pv[7:0];
          @(negedge clk);
          mul.mul_obus = '0;
        end
      end
    end
  end

  // Monitor: bus idle check every cycle, scoreboard pop on each completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        if (!mul.mul_bgn) check("ibus_zero_when_idle", 32'(mul.mul_ibus), 32'd0);
        if (done_o != 2'b00) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done_o), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_o", 32'(done_o), 32'(e.done));
            check("prod_o", 32'(prod_o), 32'(e.prod));
            check("err_o", 32'(err_o), 32'(e.err));
            check("busy_at_done", 32'(busy_o), 32'd1);
          end
        end
      end
    end
  end

  task automatic do_round(input logic [1:0] pat, input logic [7:0] xa0, input logic [7:0] xb0,
                          input logic [7:0] xa1, input logic [7:0] xb1,
                          input logic hang, input logic drop);
    int   order[$];
    int   idx = 0;
    int   budget = 400;
    logic prev_busy = 1'b0;
    op_t  o;
    exp_t e;
    if (pat == 2'b01) order.push_back(0);
    else if (pat == 2'b10) order.push_back(1);
    else begin
      order.push_back(last_srv == 1 ? 0 : 1);
      order.push_back(last_srv == 1 ? 1 : 0);
    end
    foreach (order[k]) begin
      o.a = order[k] == 0 ? xa0 : xa1;
      o.b = order[k] == 0 ? xb0 : xb1;
      o.hang = hang;
      op_q.push_back(o);
      e.done = order[k] == 0 ? 2'b01 : 2'b10;
      e.prod = hang ? 16'h0000 : smul(o.a, o.b);
      e.err  = hang;
      exp_q.push_back(e);
      if (!hang) last_srv = order[k];
    end
    @(negedge clk);
    a0_i = xa0; b0_i = xb0; a1_i = xa1; b1_i = xb1;
    req_i = pat;
    while (idx < order.size() && budget > 0) begin
      @(negedge clk);
      budget--;
      if (busy_o && !prev_busy) begin
        if (order[idx] == 0) begin a0_i = 8'($urandom); b0_i = 8'($urandom); end
        else begin a1_i = 8'($urandom); b1_i = 8'($urandom); end
        if (drop) req_i[order[idx]] = 1'b0;
      end
      if (done_o[order[idx]]) begin
        req_i[order[idx]] = 1'b0;
        idx++;
      end
      prev_busy = busy_o;
    end
    if (idx < order.size()) begin
      check("round_completion", 32'(idx), 32'(order.size()));
      req_i = '0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_prod"}, 32'(prod_o), 32'd0);
    check({tag, "_err"},  32'(err_o),  32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_bgn"},  32'(mul.mul_bgn),  32'd0);
    check({tag, "_ibus"}, 32'(mul.mul_ibus), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got timeout, expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int   wait_cnt;
    op_t  o;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_b = 1'b1;
    @(negedge clk);

    // Tie straight out of reset: requester 0 first, then 1
    do_round(2'b11, 8'd5, 8'd6, 8'd7, 8'd9, 1'b0, 1'b0);
    // Requester 0 only: 32*85 = 0x0AA0
    do_round(2'b01, 8'd32, 8'd85, 8'd0, 8'd0, 1'b0, 1'b0);
    // Requester 1 only: -3*7 = 0xFFEB, operands 0xFD / 0x07 on the bus
    do_round(2'b10, 8'd0, 8'd0, 8'hFD, 8'h07, 1'b0, 1'b0);
    // Extreme operands
    do_round(2'b11, 8'h80, 8'h80, 8'h7F, 8'h80, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_round(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'b0, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on the multiplier abandons the operation
    o.a = 8'd11; o.b = 8'd13; o.hang = 1'b1;
    op_q.push_back(o);
    @(negedge clk);
    a0_i = 8'd11; b0_i = 8'd13; req_i = 2'b01;
    wait_cnt = 0;
    while (!busy_o && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
    check("reset_test_grant", 32'(busy_o), 32'd1);
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    req_i = '0;
    op_q.delete();
    last_srv = 1;
    @(negedge clk);
    check_reset_outputs("midop_reset_hold");
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_reset", 32'(done_o), 32'd0);
    do_round(2'b11, 8'hF0, 8'd3, 8'd4, 8'hF1, 1'b0, 1'b0);
    do_round(2'b01, 8'd100, 8'hC3, 8'd0, 8'd0, 1'b0, 1'b0);

`ifdef BOOTH_ARB_TIMEOUT_EN
    // Multiplier never answers: watchdog completes with err and zero product
    do_round(2'b10, 8'd0, 8'd0, 8'd9, 8'd9, 1'b1, 1'b0);
    do_round(2'b11, 8'd2, 8'd3, 8'd4, 8'd5, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("operands_drained", 32'(op_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_arbiter.md
BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT-state cycles before the watchdog aborts the operation.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_b  input  1  asynchronous, active-low reset.
REQ-004 req_i  input  2  per-requester multiply request; bit n belongs to requester n.
REQ-005 a0_i, b0_i  input  8 each  requester 0 signed multiplicand and multiplier.
REQ-006 a1_i, b1_i  input  8 each  requester 1 signed multiplicand and multiplier.
REQ-007 done_o  output  2  one-hot, one-cycle completion pulse to the served requester.
REQ-008 prod_o  output  16  signed product, valid while done_o is nonzero and held until the next completion.
REQ-009 err_o  output  1  asserted with done_o when the operation aborted on timeout.
REQ-010 busy_o  output  1  high in every state except IDLE.
REQ-011 mul_bgn  output  1  start strobe to the Booth multiplier.
REQ-012 mul_ibus  output  8  operand bus to the multiplier.
REQ-013 mul_obus  input  8  result bus from the multiplier.
REQ-014 mul_stop  input  1  multiplier completion flag.

Function
REQ-015 FSM states: IDLE, LOAD_A, LOAD_B, WAIT, READ_HI, READ_LO, RESP; every transition occurs on a clk rising edge.
REQ-016 IDLE: when req_i is nonzero, the controller grants one requester, latches its operands into internal registers and moves to LOAD_A; otherwise it stays in IDLE.
REQ-017 Arbitration: a single request wins; when both requests are set, the requester not served last wins; last-served resets to 1, so requester 0 wins the first tie.
REQ-018 LOAD_A: mul_bgn=1 and mul_ibus=latched a; next state LOAD_B.
REQ-019 LOAD_B: mul_bgn=1 and mul_ibus=latched b; next state WAIT.
REQ-020 WAIT: mul_bgn=0 and mul_ibus=0; when mul_stop=1 the controller captures mul_obus as product[15:8] and moves to READ_HI.
REQ-021 READ_HI: captures mul_obus as product[7:0]; next state READ_LO.
REQ-022 READ_LO: updates prod_o from the captured bytes and updates last-served; next state RESP.
REQ-023 RESP: done_o[granted]=1 for exactly one cycle; next state IDLE.
REQ-024 A new grant cannot occur in the cycle after RESP; minimum request-to-done latency is 6 cycles plus the WAIT cycles.
REQ-025 Requesters hold req_i and operands until done_o; operand changes after the grant are ignored.
REQ-026 A requester that drops req_i mid-operation does not abort it; done_o still pulses.
REQ-027 mul_bgn and mul_ibus are 0 in every state other than LOAD_A and LOAD_B.

Reset
REQ-028 While rst_b=0: state=IDLE, last-served=1, timeout counter=0, and done_o, prod_o, err_o, busy_o, mul_bgn and mul_ibus are all 0.
REQ-029 Reset asserted mid-operation abandons the operation with no done_o pulse; the multiplier shares rst_b.

Configuration
REQ-030 With macro BOOTH_ARB_TIMEOUT_EN defined, a counter runs in WAIT; when it reaches TIMEOUT_CYCLES without mul_stop, the FSM goes to RESP with prod_o=0 and err_o=1 for that cycle.
REQ-031 Without BOOTH_ARB_TIMEOUT_EN, the counter is absent, WAIT lasts until mul_stop, and err_o is tied to 0.

Structure
REQ-032 Package booth_ctrl_pkg holds the FSM state enum, the operand width constant (8) and the product width constant (16).
REQ-033 Tie-break logic lives in sub-module rr_arb2 (inputs req[1:0] and last; output one-hot grant[1:0]); the rest stays in booth_arbiter.

Verification
REQ-034 Requester 0 only, a0=32, b0=85; multiplier returns 0x0A then 0xA0 -> done_o=01, prod_o=0x0AA0, err_o=0.
REQ-035 Requester 1 only, a1=-3, b1=7 -> mul_ibus is 0xFD then 0x07; done_o=10; prod_o=0xFFEB.
REQ-036 Both requests set in the same cycle from reset -> requester 0 served first, then requester 1; done_o shows 01 then 10.
REQ-037 BOOTH_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, mul_stop held 0 -> RESP after 8 WAIT cycles with done_o pulse, err_o=1 and prod_o=0.
REQ-038 rst_b driven low in WAIT -> all outputs 0 and FSM in IDLE immediately; no done_o pulse; a new request afterwards completes normally.
